// File: rtl/vector_matrix_collect.sv
// vector_matrix_collect: packs NUM_VEC handshaked vectors into one double-buffered matrix word, vector 0 in the MSB slice.
// Define VMC_FLUSH_EN to add a flush input that completes a partial frame early with zero-filled slots.
module vector_matrix_collect #(
  parameter int VEC_W = 256,
  parameter int NUM_VEC = 16,
  localparam int MAT_W = VEC_W * NUM_VEC,
  localparam int CW = $clog2(NUM_VEC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    valid_in,
  input  logic signed [VEC_W-1:0] vec_in,
  output logic                    ready_out,
  output logic [CW-1:0]           vec_idx,
  output logic signed [MAT_W-1:0] Matrix,
  output logic                    mat_valid,
  input  logic                    mat_ack,
`ifdef VMC_FLUSH_EN
  input  logic                    flush,
`endif
  output logic                    finish
);
  logic [CW-1:0] cnt;
  logic signed [MAT_W-1:0] shadow, shadow_nx;
  logic stall, accept, last, complete;
  int base;
  assign stall = mat_valid && !mat_ack;
  assign last = cnt == CW'(NUM_VEC - 1);
  assign ready_out = en && !(last && stall);
  assign accept = valid_in && ready_out;
  assign vec_idx = cnt;
`ifdef VMC_FLUSH_EN
  assign complete = (accept && last) || (en && flush && !stall && (cnt != '0 || accept));
`else
  assign complete = accept && last;
`endif
  // slots at and above cnt are always zero, so one write gives both the normal and the flushed frame
  always_comb begin
    shadow_nx = shadow;
    base = MAT_W - 1 - int'(cnt) * VEC_W;
    if (accept) shadow_nx[base -: VEC_W] = vec_in;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      shadow <= '0;
      Matrix <= '0;
      mat_valid <= 1'b0;
      finish <= 1'b0;
    end else begin
      finish <= complete;
      if (complete) begin
        Matrix <= shadow_nx;
        shadow <= '0;
        cnt <= '0;
        mat_valid <= 1'b1;
      end else begin
        if (accept) begin
          shadow <= shadow_nx;
          cnt <= cnt + 1'b1;
        end
        if (mat_ack) mat_valid <= 1'b0;
      end
    end
  end
endmodule
